// File: rtl/rr_stream_arbiter_pkg.sv
// Shared types, defaults and the round-robin pick function for the stream arbiter.
package arb_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    localparam int NUM_REQ_DEF = 4;
    localparam int DATA_W_DEF  = 32;
    localparam int MAX_REQ     = 16;

    // First set bit of valid_vec scanning upward from last_grant+1, wrapping at num_req.
    // Returns last_grant unchanged when nothing is valid; callers gate on |valid_vec.
    function automatic logic [3:0] rr_pick(
        input logic [MAX_REQ-1:0] valid_vec,
        input logic [3:0]         last_grant,
        input int                 num_req
    );
        logic [3:0] pick;
        logic [3:0] idx;
        logic       found;
        pick  = last_grant;
        found = 1'b0;
        for (int k = 1; k <= MAX_REQ; k++) begin
            idx = 4'((int'(last_grant) + k) % num_req);
            if (k <= num_req && !found && valid_vec[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/rr_stream_arbiter_if.sv
// Bundle of requester-side and consumer-side stream signals for rr_stream_arbiter.
interface rr_stream_arbiter_if
    import arb_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int ID_W    = $clog2(NUM_REQ)
);
    // A beat moves when valid and ready are both high at a rising edge; in_ready
    // may depend on in_valid and out_ready within the cycle, never on data.
    logic [NUM_REQ-1:0]        in_valid;
    logic [NUM_REQ*DATA_W-1:0] in_data;
    logic [NUM_REQ-1:0]        in_last;
    logic [NUM_REQ-1:0]        in_ready;
    logic                      out_valid;
    logic [DATA_W-1:0]         out_data;
    logic                      out_last;
    logic [ID_W-1:0]           out_id;
    logic                      out_ready;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_last, out_id
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_last, out_id
    );

endinterface

// File: rtl/rr_stream_arbiter_out_stage.sv
// One-entry valid/ready register; a load and a drain in the same cycle overwrite the entry.
module out_stage
    import arb_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] data_i,
    input  logic         out_ready_i,
    output logic         out_valid_o,
    output logic [W-1:0] out_data_o,
    output logic         stage_ready_o
);

    logic         valid_q;
    logic [W-1:0] data_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            data_q  <= data_i;
        end else if (out_ready_i) begin
            valid_q <= 1'b0;
        end
    end

    assign stage_ready_o = !valid_q || out_ready_i;
    assign out_valid_o   = valid_q;
    assign out_data_o    = data_q;

endmodule

// File: rtl/rr_stream_arbiter.sv
// Round-robin packet arbiter merging NUM_REQ streams into one registered, id-tagged stream.
module rr_stream_arbiter
    import arb_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic              clk,
    input  logic              rst,
    rr_stream_arbiter_if.slave bus,
    output arb_state_t        dbg_state_o
);

    localparam int PAY_W = ID_W + 1 + DATA_W;

    arb_state_t          state_q, state_d;
    logic [ID_W-1:0]     lock_id_q, lock_id_d;
    logic [ID_W-1:0]     last_grant_q, last_grant_d;
    logic [ID_W-1:0]     grant_id;
    logic [3:0]          cand;
    logic [MAX_REQ-1:0]  valid_ext;
    logic                grant_en;
    logic                stage_ready;
    logic                accept;
    logic                sel_last;
    logic [DATA_W-1:0]   sel_data;
    logic [NUM_REQ-1:0]  in_ready;
    logic [PAY_W-1:0]    stage_q_data;

    assign valid_ext = MAX_REQ'(bus.in_valid);
    assign cand      = rr_pick(valid_ext, 4'(last_grant_q), NUM_REQ);

    // The owner keeps the grant while locked, even with its valid low, so others stall.
    assign grant_id = (state_q == LOCKED) ? lock_id_q : ID_W'(cand);
    assign grant_en = (state_q == LOCKED) || (|bus.in_valid);

    always_comb begin
        in_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            in_ready[i] = !rst && grant_en && stage_ready && (grant_id == ID_W'(i));
        end
    end

    assign bus.in_ready = in_ready;
    assign accept       = |(bus.in_valid & in_ready);
    assign sel_last     = bus.in_last[grant_id];
    assign sel_data     = bus.in_data[int'(grant_id)*DATA_W +: DATA_W];

    always_comb begin
        state_d      = state_q;
        lock_id_d    = lock_id_q;
        last_grant_d = last_grant_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    last_grant_d = ID_W'(cand);
                    if (!sel_last) begin
                        state_d   = LOCKED;
                        lock_id_d = ID_W'(cand);
                    end
                end
            end
            LOCKED: begin
                if (accept && sel_last) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            lock_id_q    <= '0;
            last_grant_q <= ID_W'(NUM_REQ - 1);
        end else begin
            state_q      <= state_d;
            lock_id_q    <= lock_id_d;
            last_grant_q <= last_grant_d;
        end
    end

    out_stage #(
        .W(PAY_W)
    ) u_out_stage (
        .clk          (clk),
        .rst          (rst),
        .load_i       (accept),
        .data_i       ({grant_id, sel_last, sel_data}),
        .out_ready_i  (bus.out_ready),
        .out_valid_o  (bus.out_valid),
        .out_data_o   (stage_q_data),
        .stage_ready_o(stage_ready)
    );

    assign bus.out_id   = stage_q_data[PAY_W-1 -: ID_W];
    assign bus.out_last = stage_q_data[DATA_W];
    assign bus.out_data = stage_q_data[DATA_W-1:0];
    assign dbg_state_o  = state_q;

endmodule

// File: doc/rr_stream_arbiter.md
# rr_stream_arbiter

Round-robin arbiter that shares one registered valid/ready output stage among NUM_REQ independent 32-bit stream requesters. Packets are multi-beat, delimited by `in_last`. A granted requester keeps ownership until its last beat is accepted. The block sits in front of a single downstream pipeline consumer: it merges several producers into one stream, tags each beat with its source id, and adds exactly one register stage of latency.

## Interface
- `NUM_REQ`, default 4: number of requesters, 2..16.
- `DATA_W`, default 32: beat width in bits.
- `ID_W`, default `$clog2(NUM_REQ)`: width of the source-id field.
- `clk` input 1: single clock; all logic on its rising edge.
- `rst` input 1: synchronous, active-high reset.
- `in_valid` input NUM_REQ: per-requester beat valid.
- `in_data` input NUM_REQ*DATA_W: requester i occupies bits [i*DATA_W +: DATA_W].
- `in_last` input NUM_REQ: per-requester end-of-packet flag.
- `in_ready` output NUM_REQ: per-requester accept; at most one bit high.
- `out_valid` output 1: registered beat valid.
- `out_data` output DATA_W: registered beat.
- `out_last` output 1: registered end-of-packet.
- `out_id` output ID_W: index of the requester that produced the beat.
- `out_ready` input 1: downstream accept.

## Operation
- Output stage: one-entry register (data, last, id, valid). `stage_ready = !out_valid || out_ready`.
- FSM states:
  - IDLE: no packet owned.
  - LOCKED: packet in progress, owner in `lock_id`.
- IDLE behaviour:
  - Candidate = first i with `in_valid[i]`, scanning from `(last_grant+1) mod NUM_REQ` upward with wrap.
  - `in_ready[cand] = stage_ready`; all other bits 0.
  - On an accepted beat with `in_last=0`: go to LOCKED with `lock_id=cand`.
  - On an accepted beat with `in_last=1`: stay in IDLE.
  - In both cases `last_grant <= cand`.
- LOCKED behaviour:
  - `in_ready[lock_id] = stage_ready`; all other bits 0, whatever their valid.
  - On an accepted beat with `in_last=1`: go to IDLE.
  - If the owner drops valid mid-packet, the lock holds, bubbles are inserted, and no other requester is granted.
- Transfer rules:
  - Accept = `in_valid[i] && in_ready[i]`. On accept the stage loads data, last, and id=i, and sets `out_valid=1`.
  - Otherwise, `out_valid && out_ready` clears `out_valid`.
  - Load and drain in the same cycle are allowed: the stage is overwritten and `out_valid` stays 1.
- `in_ready` may depend combinationally on `in_valid` and `out_ready`. There is no combinational path from `in_data` to any output.
- Fairness: after a requester's packet ends, every other requester with valid asserted is served before it is served again. Worst-case wait is NUM_REQ-1 packets.

## Timing
- Latency: 1 cycle from input accept edge to `out_valid`.
- Throughput: one beat per cycle while `out_ready=1`, including back-to-back packets from different requesters. No arbitration bubble between packets.
- Reset values, effective on the first rising edge with `rst=1`:
  - `out_valid=0`, `out_data=0`, `out_last=0`, `out_id=0`.
  - State IDLE, `last_grant=NUM_REQ-1`, so requester 0 has first priority.
  - `in_ready` all 0 while `rst=1`.
- Reset mid-packet: the stage contents and the lock are discarded. The partial packet is not completed.
- Backpressure: while `out_valid=1 && out_ready=0`, `out_data`, `out_last` and `out_id` hold stable and all `in_ready` bits are 0.
- Wrap-around: the scan from `last_grant=NUM_REQ-1` starts at 0.

## Structure
- Package `arb_pkg`:
  - `typedef enum logic {IDLE, LOCKED} arb_state_t`.
  - Default constants `NUM_REQ_DEF=4` and `DATA_W_DEF=32`.
  - A function returning the round-robin candidate index from `(valid_vec, last_grant)`.
- Sub-module `out_stage`: a one-entry valid/ready register over `{id, last, data}`, exporting `stage_ready`. It is instantiated once.
- The top level holds the FSM, `lock_id`, `last_grant` and the `in_ready` decode.

## Test plan
- Reset, then requester 2 sends a single beat 0x2222_2222 with last=1 while `out_ready=1`:
  - Next cycle: `out_valid=1`, `out_data=0x2222_2222`, `out_id=2`, `out_last=1`.
  - All `in_ready` bits were 0 during reset.
- All four requesters hold valid, each sending 1-beat packets of 0xA0..0xA3, with `out_ready=1`:
  - Output order is id 0,1,2,3,0,1,… with one beat per cycle and no gaps.
- Requester 1 sends a 3-beat packet 0x11,0x12,0x13(last) while requester 0 keeps valid:
  - The three 0x1x beats appear contiguously with `out_id=1`.
  - Requester 0 is granted on the cycle after 0x13 is accepted.
- Requester 0 mid-packet drops valid for 2 cycles while requester 3 is valid:
  - `in_ready[3]` stays 0 and the output shows 2 bubbles.
  - The packet resumes with `out_id=0`.
- `out_ready=0` for 3 cycles with beat 0xDEAD_BEEF held in the stage:
  - Outputs stay stable and `in_ready=0`.
  - When `out_ready` rises, the stage drains and refills in the same cycle.
- Assert `rst` mid-packet from requester 2:
  - Next cycle: `out_valid=0` and state is IDLE.
  - After release, requester 0 wins over requester 2 when both are valid.
